xm_mem_ctrl: RTL
================

# xm_mem_ctrl

Parametrised memory controller that connects the xm_cpu datapath memory port (enable, read/write, byte-op, address, write data) to the CPU's Wishbone-style classic bus master signals. It performs one transfer per request. It generalises word width and byte-lane count, and steers byte lanes for byte operations. It adds misaligned-access detection, bus-error handling and a bus timeout, and reports all three as bad-memory faults to the control plane.

## Interface
Parameters:
- WORD, 16: data width in bits; a multiple of 8, at least 16.
- ADDR, 16: address width in bits.
- TIMEOUT, 15: maximum bus cycles to wait for a response; 0 disables the timeout.

Ports:
- clk_i  in  1  single clock; every register is updated on the rising edge.
- arst_i  in  1  reset, synchronous and active-high.
- memEn_i  in  1  request strobe; sampled only in IDLE.
- memWr_i  in  1  1 = write, 0 = read; sampled with memEn_i.
- byteOp_i  in  1  1 = byte access, 0 = word access.
- adr_i  in  ADDR  byte address.
- wdat_i  in  WORD  write data; for byte ops, bits [7:0] are used.
- memBusy_o  out  1  high while a transaction is in progress (state is not IDLE).
- memDone_o  out  1  one-cycle pulse when a transaction ends, whether by success or fault.
- badMem_o  out  1  one-cycle pulse, coincident with memDone_o, when the transaction faulted.
- rdat_o  out  WORD  read result; byte reads are zero-extended.
- ack_i  in  1  bus acknowledge.
- err_i  in  1  bus error.
- dat_i  in  WORD  bus read data.
- cyc_o, stb_o, we_o  out  1  bus cycle, strobe and write enable.
- sel_o  out  WORD/8  byte-lane selects.
- adr_o  out  ADDR  bus address.
- dat_o  out  WORD  bus write data.

## Operation
- FSM states: IDLE, BUS, RESP, FAULT.
- Lane field: LB = log2(WORD/8). Lane index = adr_i[LB-1:0].
- **IDLE, memEn_i=1, word access with lane index not 0:** go to FAULT (misaligned). No bus cycle is started.
- **IDLE, memEn_i=1, aligned:** latch the request and go to BUS.
  - The latched request is: adr_i, memWr_i, byteOp_i, and the lane-steered data and select.
  - Word access: sel = all ones; dat = wdat_i.
  - Byte access: sel = one-hot at the lane index; dat = wdat_i[7:0] replicated into every lane.
- **BUS:** cyc_o = stb_o = 1. we_o, sel_o, adr_o and dat_o are driven from the latched request. Exit priority:
  - err_i → FAULT.
  - else ack_i → RESP. On a read, load rdat_o from dat_i: either the whole word, or the selected lane zero-extended.
  - else, if TIMEOUT>0 and the wait counter equals TIMEOUT → FAULT.
- **RESP:** memDone_o=1, then go to IDLE.
- **FAULT:** memDone_o=1 and badMem_o=1, then go to IDLE.
- memEn_i outside IDLE is ignored; the request is not queued.
- rdat_o changes only on a successful read. It holds its value across writes and faults.
- The wait counter is $clog2(TIMEOUT+1) bits wide. It clears on entry to BUS and increments on every BUS cycle without a response. It saturates; it never wraps.
- **Reset:** reset mid-transaction returns the FSM to IDLE immediately and drops cyc_o and stb_o in the same edge. No done or fault pulse is generated for the aborted transaction.

## Timing
- **Reset values:** state=IDLE. memBusy_o, memDone_o, badMem_o, cyc_o, stb_o and we_o are 0. sel_o, adr_o, dat_o and rdat_o are 0.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- **Request accepted at edge N:**
  - cyc_o and stb_o are high from N+1.
  - An ack_i sampled at edge N+k gives RESP in cycle N+k+1.
  - cyc_o is low in the RESP cycle.
- **Latencies:**
  - Zero-wait-state slave: 3 cycles from request to memDone_o.
  - Misaligned access: memDone_o and badMem_o one cycle after the request.
  - Timeout: fault after TIMEOUT BUS cycles without ack_i or err_i.
- Back-to-back operation: a new request can be accepted in the IDLE cycle that follows RESP or FAULT.
- **Boundary cases:**
  - ack_i and err_i together → fault.
  - ack_i in the same cycle the counter reaches TIMEOUT → success.

## Structure
- Shared package xm_pkg holds:
  - the xm_mem_state_t enum {IDLE, BUS, RESP, FAULT};
  - the lane constant function xm_lane_bits(WORD);
  - the bus-width localparams.
- One sub-module is natural: xm_byte_lane.
  - It is combinational and parametrised by WORD.
  - Write path: byte replication and one-hot select generation.
  - Read path: lane extraction and zero extension.
- The FSM and the counter stay in xm_mem_ctrl.

## Test plan
All scenarios use WORD=16 and TIMEOUT=4.
- **Word read:** adr_i=0x0100, read, slave acks on the first BUS cycle with dat_i=0xBEEF → sel_o=2'b11, rdat_o=0xBEEF, memDone_o at cycle 3, badMem_o=0.
- **Byte write:** adr_i=0x0103, wdat_i=0x00A5 → sel_o=2'b10, dat_o=0xA5A5, we_o=1. A subsequent byte read of 0x0103 with dat_i=0x5A00 → rdat_o=0x005A.
- **Misaligned word write:** adr_i=0x0101 → cyc_o stays 0, memDone_o and badMem_o pulse one cycle later, rdat_o unchanged.
- **Timeout:** slave never responds → cyc_o high for exactly 4 cycles, then badMem_o pulses. Also check the variant where ack_i arrives in BUS cycle 4: the transaction succeeds.
- **Error priority:** ack_i and err_i asserted together → FAULT. Also check: memEn_i pulsed while in BUS is ignored, and the next request in the IDLE cycle after FAULT is accepted.
- **Reset mid-BUS:** assert arst_i during BUS → cyc_o=0 on the next edge, no memDone_o pulse, all outputs at their reset values.

Source files
------------

// File: rtl/xm_pkg.sv
// xm_pkg: shared state encoding, lane-width helper and default bus widths for the xm memory port.
package xm_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} xm_mem_state_t;
    localparam int XM_WORD    = 16;
    localparam int XM_ADDR    = 16;
    localparam int XM_TIMEOUT = 15;
    function automatic int xm_lane_bits(int word);
        return $clog2(word / 8);
    endfunction
endpackage

// File: rtl/xm_byte_lane.sv
// xm_byte_lane: byte replication and one-hot lane select on writes, lane extraction with zero extension on reads.
module xm_byte_lane import xm_pkg::*; #(
    parameter int WORD = XM_WORD
) (
    input  logic                          w_byte_i,
    input  logic [xm_lane_bits(WORD)-1:0] w_lane_i,
    input  logic [WORD-1:0]               wdat_i,
    output logic [WORD/8-1:0]             sel_o,
    output logic [WORD-1:0]               dat_o,
    input  logic                          r_byte_i,
    input  logic [xm_lane_bits(WORD)-1:0] r_lane_i,
    input  logic [WORD-1:0]               bus_dat_i,
    output logic [WORD-1:0]               rdat_o
);
    localparam int NB = WORD / 8;
    always_comb begin
        sel_o  = w_byte_i ? NB'(1) << w_lane_i : '1;
        dat_o  = w_byte_i ? {NB{wdat_i[7:0]}} : wdat_i;
        rdat_o = r_byte_i ? {{(WORD-8){1'b0}}, 8'(bus_dat_i >> {r_lane_i, 3'b000})} : bus_dat_i;
    end
endmodule

// File: rtl/xm_mem_ctrl.sv
// xm_mem_ctrl: one-transfer-per-request bridge from the xm_cpu memory port to a classic Wishbone master,
// reporting misalignment, bus errors and timeouts as bad-memory faults.
module xm_mem_ctrl import xm_pkg::*; #(
    parameter int WORD    = XM_WORD,
    parameter int ADDR    = XM_ADDR,
    parameter int TIMEOUT = XM_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              memEn_i,
    input  logic              memWr_i,
    input  logic              byteOp_i,
    input  logic [ADDR-1:0]   adr_i,
    input  logic [WORD-1:0]   wdat_i,
    output logic              memBusy_o,
    output logic              memDone_o,
    output logic              badMem_o,
    output logic [WORD-1:0]   rdat_o,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [WORD-1:0]   dat_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [WORD/8-1:0] sel_o,
    output logic [ADDR-1:0]   adr_o,
    output logic [WORD-1:0]   dat_o
);
    localparam int LB = xm_lane_bits(WORD);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    xm_mem_state_t state_q;
    logic we_q, byte_q, timeout;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WORD/8-1:0] sel_d;
    logic [WORD-1:0] dat_d, rdat_d;
    xm_byte_lane #(.WORD(WORD)) u_lane (
        .w_byte_i (byteOp_i),
        .w_lane_i (adr_i[LB-1:0]),
        .wdat_i   (wdat_i),
        .sel_o    (sel_d),
        .dat_o    (dat_d),
        .r_byte_i (byte_q),
        .r_lane_i (adr_o[LB-1:0]),
        .bus_dat_i(dat_i),
        .rdat_o   (rdat_d)
    );
    // cnt_d counts the current BUS cycle, so the fault fires after exactly TIMEOUT silent cycles
    assign cnt_d     = &cnt_q ? cnt_q : cnt_q + CW'(1);
    assign timeout   = (TIMEOUT > 0) && (cnt_d == CW'(TIMEOUT));
    assign memBusy_o = state_q != IDLE;
    assign memDone_o = state_q == RESP || state_q == FAULT;
    assign badMem_o  = state_q == FAULT;
    assign cyc_o     = state_q == BUS;
    assign stb_o     = state_q == BUS;
    assign we_o      = state_q == BUS && we_q;
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            cnt_q   <= '0;
            sel_o   <= '0;
            adr_o   <= '0;
            dat_o   <= '0;
            rdat_o  <= '0;
        end else begin
            case (state_q)
                IDLE: if (memEn_i) begin
                    if (!byteOp_i && adr_i[LB-1:0] != '0) begin
                        state_q <= FAULT;
                    end else begin
                        state_q <= BUS;
                        we_q    <= memWr_i;
                        byte_q  <= byteOp_i;
                        adr_o   <= adr_i;
                        sel_o   <= sel_d;
                        dat_o   <= dat_d;
                        cnt_q   <= '0;
                    end
                end
                BUS: if (err_i) begin
                    state_q <= FAULT;
                end else if (ack_i) begin
                    state_q <= RESP;
                    if (!we_q) rdat_o <= rdat_d;
                end else if (timeout) begin
                    state_q <= FAULT;
                end else begin
                    cnt_q <= cnt_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
